// File: rtl/ex_stage_p.sv
// Parametrised execute stage: single-cycle ALU/shifter with registered results and flags.
// Define EX_MUL_EN to compile in the multi-cycle shift-add multiplier (FS=0011) and its MULT state.
module ex_stage_p #(
    parameter int W   = 8,
    parameter int SHW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   PC_2,
    input  logic [W-1:0]   BuA,
    input  logic [W-1:0]   BuB,
    input  logic [W-1:0]   MRD,
    input  logic [3:0]     FS,
    input  logic [SHW-1:0] SH,
    input  logic [2:0]     DA,
    input  logic [1:0]     MD,
    input  logic [1:0]     BS,
    input  logic           RW,
    input  logic           PS,
    input  logic           MW,
    output logic [W-1:0]   BrA,
    output logic [W-1:0]   RAA,
    output logic [W-1:0]   MEA,
    output logic [W-1:0]   MWD,
    output logic [1:0]     BSO,
    output logic           PSO,
    output logic           MWO,
    output logic           Zw,
    output logic           busy,
    output logic [W-1:0]   FU,
    output logic [W-1:0]   MEM,
    output logic [2:0]     DAO,
    output logic [1:0]     MDO,
    output logic           RWO,
    output logic           out_valid,
    output logic           Z,
    output logic           C,
    output logic           N,
    output logic           V,
    output logic           LT,
    output logic           ILL,
    output logic [1:0]     fsm_state
);

    localparam logic [3:0] OP_PASS0 = 4'b0000;
    localparam logic [3:0] OP_PASS7 = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1010;
    localparam logic [3:0] OP_XOR   = 4'b1100;
    localparam logic [3:0] OP_NOT   = 4'b1110;
    localparam logic [3:0] OP_SHL   = 4'b0100;
    localparam logic [3:0] OP_SHR   = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a bundle is consumed on a falling edge where in_valid & ~busy;
    // while busy is high upstream must hold its bundle, nothing is consumed.
    logic accept;
    logic start_mul;

    // ---------------- combinational pass-through outputs ----------------
    assign BrA = PC_2 + BuB;
    assign RAA = BuA;
    assign MEA = BuA;
    assign MWD = BuB;
    assign BSO = BS;
    assign PSO = PS;
    assign MWO = MW & in_valid & ~busy;

    // ---------------- single-cycle ALU ----------------
    logic [W:0]   add_ext;
    logic [W:0]   sub_ext;
    logic         sh_over;
    logic [W-1:0] s_f;
    logic         s_c;
    logic         s_v;
    logic         s_ill;
    logic         s_n;
    logic         s_z;

    assign add_ext = {1'b0, BuA} + {1'b0, BuB};
    // Bit W of the extended difference is the borrow (A < B unsigned).
    assign sub_ext = {1'b0, BuA} - {1'b0, BuB};
    assign sh_over = (32'(SH) >= 32'(W));

    always_comb begin
        s_f   = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_ill = 1'b0;
        case (FS)
            OP_PASS0, OP_PASS7: s_f = BuA;
            OP_ADD: begin
                s_f = add_ext[W-1:0];
                s_c = add_ext[W];
                s_v = (BuA[W-1] == BuB[W-1]) && (add_ext[W-1] != BuA[W-1]);
            end
            OP_SUB: begin
                s_f = sub_ext[W-1:0];
                s_c = sub_ext[W];
                s_v = (BuA[W-1] != BuB[W-1]) && (sub_ext[W-1] != BuA[W-1]);
            end
            OP_AND: s_f = BuA & BuB;
            OP_OR:  s_f = BuA | BuB;
            OP_XOR: s_f = BuA ^ BuB;
            OP_NOT: s_f = ~BuA;
            OP_SHL: s_f = sh_over ? '0 : (BuA << SH);
            OP_SHR: s_f = sh_over ? '0 : (BuA >> SH);
`ifdef EX_MUL_EN
            // Legal, but its result comes from the multiplier, not this path.
            4'b0011: s_f = '0;
`endif
            default: s_ill = 1'b1;
        endcase
    end

    assign s_n = s_f[W-1];
    assign s_z = ~|s_f;
    assign Zw  = s_z;

`ifdef EX_MUL_EN
    // ---------------- shift-add multiplier ----------------
    localparam int CW = $clog2(W);

    state_t          state_q;
    state_t          state_d;
    logic [2*W-1:0]  mcand_q;
    logic [2*W-1:0]  acc_q;
    logic [2*W-1:0]  acc_step;
    logic [W-1:0]    mplr_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      m_da;
    logic [1:0]      m_md;
    logic            m_rw;
    logic [W-1:0]    m_mrd;
    logic            mul_last;

    assign busy      = (state_q == S_MULT);
    assign accept    = in_valid & ~busy;
    assign start_mul = accept & (FS == 4'b0011);
    assign acc_step  = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign mul_last  = busy & (cnt_q == CW'(W - 1));
    assign fsm_state = state_q;

    always_ff @(negedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = start_mul ? S_MULT : S_IDLE;
            S_MULT:         if (cnt_q == CW'(W - 1)) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            m_da    <= '0;
            m_md    <= '0;
            m_rw    <= 1'b0;
            m_mrd   <= '0;
        end else if (start_mul) begin
            mcand_q <= {{W{1'b0}}, BuA};
            mplr_q  <= BuB;
            acc_q   <= '0;
            cnt_q   <= '0;
            m_da    <= DA;
            m_md    <= MD;
            m_rw    <= RW;
            m_mrd   <= MRD;
        end else if (busy) begin
            acc_q   <= acc_step;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
        end
    end
`else
    assign busy      = 1'b0;
    assign accept    = in_valid;
    assign start_mul = 1'b0;
    assign fsm_state = S_IDLE;
`endif

    // ---------------- registered results ----------------
    always_ff @(negedge clk) begin
        if (rst) begin
            FU        <= '0;
            MEM       <= '0;
            DAO       <= '0;
            MDO       <= '0;
            RWO       <= 1'b0;
            out_valid <= 1'b0;
            Z         <= 1'b0;
            C         <= 1'b0;
            N         <= 1'b0;
            V         <= 1'b0;
            LT        <= 1'b0;
            ILL       <= 1'b0;
        end else if (accept && !start_mul) begin
            FU        <= s_f;
            MEM       <= MRD;
            DAO       <= DA;
            MDO       <= MD;
            RWO       <= RW;
            out_valid <= 1'b1;
            Z         <= s_z;
            C         <= s_c;
            N         <= s_n;
            V         <= s_v;
            LT        <= s_n ^ s_v;
            ILL       <= s_ill;
`ifdef EX_MUL_EN
        end else if (mul_last) begin
            // Final iteration's sum is written directly so busy and the result share an edge.
            FU        <= acc_step[W-1:0];
            MEM       <= m_mrd;
            DAO       <= m_da;
            MDO       <= m_md;
            RWO       <= m_rw;
            out_valid <= 1'b1;
            Z         <= ~|acc_step[W-1:0];
            C         <= |acc_step[2*W-1:W];
            N         <= acc_step[W-1];
            V         <= 1'b0;
            LT        <= acc_step[W-1];
            ILL       <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            RWO       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_p.sv
// Self-checking bench for ex_stage_p: directed table, hand-written multi-cycle sequences
// and randomized ops checked against an arithmetic reference model.
module tb_ex_stage_p;

    localparam int W   = 8;
    localparam int SHW = 4;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [3:0] F_ADD = 4'b0010;
    localparam logic [3:0] F_SUB = 4'b0101;
    localparam logic [3:0] F_MUL = 4'b0011;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   PC_2, BuA, BuB, MRD;
    logic [3:0]     FS;
    logic [SHW-1:0] SH;
    logic [2:0]     DA;
    logic [1:0]     MD, BS;
    logic           RW, PS, MW;
    logic [W-1:0]   BrA, RAA, MEA, MWD;
    logic [1:0]     BSO;
    logic           PSO, MWO, Zw, busy;
    logic [W-1:0]   FU, MEM;
    logic [2:0]     DAO;
    logic [1:0]     MDO;
    logic           RWO, out_valid, Z, C, N, V, LT, ILL;
    logic [1:0]     fsm_state;

    ex_stage_p #(.W(W), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .PC_2(PC_2), .BuA(BuA), .BuB(BuB), .MRD(MRD),
        .FS(FS), .SH(SH), .DA(DA), .MD(MD), .BS(BS),
        .RW(RW), .PS(PS), .MW(MW),
        .BrA(BrA), .RAA(RAA), .MEA(MEA), .MWD(MWD),
        .BSO(BSO), .PSO(PSO), .MWO(MWO), .Zw(Zw), .busy(busy),
        .FU(FU), .MEM(MEM), .DAO(DAO), .MDO(MDO),
        .RWO(RWO), .out_valid(out_valid),
        .Z(Z), .C(C), .N(N), .V(V), .LT(LT), .ILL(ILL),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: plain arithmetic on the operand values
    function automatic void model(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [SHW-1:0] sh, output logic [W-1:0] f,
                                  output logic c, output logic v, output logic ill);
        longint m, ua, ub, sa, sb, r, s, ish;
        m   = longint'(1) << W;
        ua  = longint'(a);
        ub  = longint'(b);
        ish = longint'(sh);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        f = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (fs)
            4'b0000, 4'b0111: f = a;
            4'b0010: begin
                r = ua + ub; f = W'(r % m); c = (r >= m);
                s = sa + sb; v = (s >= m / 2) || (s < -(m / 2));
            end
            4'b0101: begin
                f = W'((ua - ub + m) % m); c = (ua < ub);
                s = sa - sb; v = (s >= m / 2) || (s < -(m / 2));
            end
            4'b1000: f = a & b;
            4'b1010: f = a | b;
            4'b1100: f = a ^ b;
            4'b1110: f = ~a;
            4'b0100: f = (ish >= W) ? '0 : W'((ua * (longint'(1) << ish)) % m);
            4'b1001: f = (ish >= W) ? '0 : W'(ua / (longint'(1) << ish));
            4'b0011: begin
                if (MUL_EN) begin
                    r = ua * ub; f = W'(r % m); c = (r >= m);
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // driver tasks (call right after a rising edge)
    task automatic drive(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] sh, input logic [W-1:0] pc2, input logic [W-1:0] mrd,
                         input logic [2:0] da, input logic [1:0] md, input logic [1:0] bs,
                         input logic rw, input logic ps, input logic mw);
        FS = fs; BuA = a; BuB = b; SH = sh; PC_2 = pc2; MRD = mrd;
        DA = da; MD = md; BS = bs; RW = rw; PS = ps; MW = mw;
        in_valid = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":fu"}, 32'(FU), 32'd0);
        chk({tag, ":mem"}, 32'(MEM), 32'd0);
        chk({tag, ":dao"}, 32'(DAO), 32'd0);
        chk({tag, ":mdo"}, 32'(MDO), 32'd0);
        chk({tag, ":rwo"}, 32'(RWO), 32'd0);
        chk({tag, ":out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ":z"}, 32'(Z), 32'd0);
        chk({tag, ":c"}, 32'(C), 32'd0);
        chk({tag, ":n"}, 32'(N), 32'd0);
        chk({tag, ":v"}, 32'(V), 32'd0);
        chk({tag, ":lt"}, 32'(LT), 32'd0);
        chk({tag, ":ill"}, 32'(ILL), 32'd0);
        chk({tag, ":busy"}, 32'(busy), 32'd0);
        chk({tag, ":state"}, 32'(fsm_state), 32'd0);
    endtask

    // one op with random side-band controls; waits (bounded) for its result
    task automatic run_op(input string name, input logic [3:0] fs, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [SHW-1:0] sh, input logic [W-1:0] ef,
                          input logic ec, input logic ev, input logic eill);
        logic [W-1:0] pc2, mrd;
        logic [2:0]   da;
        logic [1:0]   md, bs;
        logic         rw, ps, mw, mul, en;
        int           lat, exp_lat, busy_cnt, exp_bra;
        pc2 = W'($urandom);
        mrd = W'($urandom);
        da  = 3'($urandom_range(0, 7));
        md  = 2'($urandom_range(0, 3));
        bs  = 2'($urandom_range(0, 3));
        rw  = 1'($urandom_range(0, 1));
        ps  = 1'($urandom_range(0, 1));
        mw  = 1'($urandom_range(0, 1));
        mul = MUL_EN && (fs == F_MUL);
        en  = ef[W-1];
        @(posedge clk);
        drive(fs, a, b, sh, pc2, mrd, da, md, bs, rw, ps, mw);
        #1;
        exp_bra = (int'(pc2) + int'(b)) % (1 << W);
        chk({name, ":bra"}, 32'(BrA), exp_bra);
        chk({name, ":raa"}, 32'(RAA), 32'(a));
        chk({name, ":mea"}, 32'(MEA), 32'(a));
        chk({name, ":mwd"}, 32'(MWD), 32'(b));
        chk({name, ":bso"}, 32'(BSO), 32'(bs));
        chk({name, ":pso"}, 32'(PSO), 32'(ps));
        chk({name, ":mwo"}, 32'(MWO), 32'(mw));
        if (!mul) chk({name, ":zw"}, 32'(Zw), 32'(ef == '0));
        exp_lat  = mul ? W + 1 : 1;
        lat      = 0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1 || lat > exp_lat + 3) break;
        end
        chk({name, ":latency"}, lat, exp_lat);
        chk({name, ":busy_cycles"}, busy_cnt, mul ? W : 0);
        chk({name, ":out_valid"}, 32'(out_valid), 32'd1);
        chk({name, ":busy_end"}, 32'(busy), 32'd0);
        chk({name, ":fu"}, 32'(FU), 32'(ef));
        chk({name, ":c"}, 32'(C), 32'(ec));
        chk({name, ":v"}, 32'(V), 32'(ev));
        chk({name, ":n"}, 32'(N), 32'(en));
        chk({name, ":z"}, 32'(Z), 32'(ef == '0));
        chk({name, ":lt"}, 32'(LT), 32'(en ^ ev));
        chk({name, ":ill"}, 32'(ILL), 32'(eill));
        chk({name, ":dao"}, 32'(DAO), 32'(da));
        chk({name, ":mdo"}, 32'(MDO), 32'(md));
        chk({name, ":rwo"}, 32'(RWO), 32'(rw));
        chk({name, ":mem"}, 32'(MEM), 32'(mrd));
    endtask

    typedef struct {
        logic [3:0]     fs;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [SHW-1:0] sh;
        logic [W-1:0]   f;
        logic           c;
        logic           v;
        logic           ill;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [3:0]     fs;
        logic [W-1:0]   a, b, ef;
        logic [SHW-1:0] sh;
        logic           ec, ev, eill;
        int             lat, busy_cnt, ov_seen;

        tbl[0]  = '{4'b0010, 8'h7F, 8'h01, 4'd0,  8'h80, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'b0101, 8'h03, 8'h05, 4'd0,  8'hFE, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'b1001, 8'h80, 8'h00, 4'd7,  8'h01, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 8'h5A, 8'hA5, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'b0010, 8'hFF, 8'h01, 4'd0,  8'h00, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'b0101, 8'h80, 8'h01, 4'd0,  8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4'b1000, 8'hF0, 8'h3C, 4'd0,  8'h30, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{4'b1010, 8'hF0, 8'h0F, 4'd0,  8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'b1100, 8'hFF, 8'h0F, 4'd0,  8'hF0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{4'b1110, 8'h5A, 8'h00, 4'd0,  8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'b0100, 8'h81, 8'h00, 4'd1,  8'h02, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4'b0100, 8'hFF, 8'h00, 4'd8,  8'h00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{4'b1001, 8'hFF, 8'h00, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{4'b0000, 8'h9C, 8'h11, 4'd0,  8'h9C, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'b0111, 8'h01, 8'h22, 4'd0,  8'h01, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{4'b0110, 8'h33, 8'h44, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{4'b0011, 8'h0F, 8'h11, 4'd0,  MUL_EN ? 8'hFF : 8'h00, 1'b0, 1'b0, !MUL_EN};
        tbl[17] = '{4'b0011, 8'h10, 8'h10, 4'd0,  8'h00, MUL_EN, 1'b0, !MUL_EN};
        tbl[18] = '{4'b0011, 8'hFF, 8'hFF, 4'd0,  MUL_EN ? 8'h01 : 8'h00, MUL_EN, 1'b0, !MUL_EN};
        tbl[19] = '{4'b1101, 8'h12, 8'h34, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0;
        PC_2 = '0; BuA = '0; BuB = '0; MRD = '0; FS = '0; SH = '0;
        DA = '0; MD = '0; BS = '0; RW = 1'b0; PS = 1'b0; MW = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");
        @(posedge clk);
        rst = 1'b0;

        // directed table, back-to-back
        for (int i = 0; i < 20; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].fs, tbl[i].a, tbl[i].b, tbl[i].sh,
                   tbl[i].f, tbl[i].c, tbl[i].v, tbl[i].ill);

        // hold: two idle cycles after an ADD keep results, drop out_valid/RWO
        @(posedge clk);
        drive(F_ADD, 8'h7F, 8'h01, '0, 8'h00, 8'h66, 3'd6, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("hold:ov_first", 32'(out_valid), 32'd1);
        chk("hold:rwo_first", 32'(RWO), 32'd1);
        @(posedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("hold:out_valid", 32'(out_valid), 32'd0);
            chk("hold:rwo", 32'(RWO), 32'd0);
            chk("hold:fu", 32'(FU), 32'h80);
            chk("hold:v", 32'(V), 32'd1);
            chk("hold:n", 32'(N), 32'd1);
            chk("hold:dao", 32'(DAO), 32'd6);
        end

        // BrA wraps modulo 2^W
        @(posedge clk);
        PC_2 = 8'hFE; BuB = 8'h04;
        #1;
        chk("bra_wrap", 32'(BrA), 32'h02);

`ifdef EX_MUL_EN
        // a bundle presented while busy is held, then consumed exactly once
        @(posedge clk);
        drive(F_MUL, 8'h0F, 8'h11, '0, 8'h10, 8'hA5, 3'd5, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1);
        @(negedge clk); #1;
        chk("mulhold:busy_start", 32'(busy), 32'd1);
        chk("mulhold:ov_start", 32'(out_valid), 32'd0);
        @(posedge clk);
        drive(F_ADD, 8'h01, 8'h02, '0, 8'h20, 8'h3C, 3'd3, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("mulhold:mwo_busy", 32'(MWO), 32'd0);
        lat = 1;
        busy_cnt = 1;
        forever begin
            @(negedge clk); #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1 || lat > W + 4) break;
        end
        chk("mulhold:latency", lat, W + 1);
        chk("mulhold:busy_cycles", busy_cnt, W);
        chk("mulhold:fu", 32'(FU), 32'hFF);
        chk("mulhold:c", 32'(C), 32'd0);
        chk("mulhold:dao", 32'(DAO), 32'd5);
        chk("mulhold:mdo", 32'(MDO), 32'd2);
        chk("mulhold:rwo", 32'(RWO), 32'd1);
        chk("mulhold:mem", 32'(MEM), 32'hA5);
        @(negedge clk); #1;
        chk("mulhold:next_ov", 32'(out_valid), 32'd1);
        chk("mulhold:next_fu", 32'(FU), 32'h03);
        chk("mulhold:next_dao", 32'(DAO), 32'd3);
        chk("mulhold:next_rwo", 32'(RWO), 32'd0);
        chk("mulhold:next_mem", 32'(MEM), 32'h3C);
        @(posedge clk);
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("mulhold:once", 32'(out_valid), 32'd0);
`endif

        // reset during a multiply aborts it
        run_op("pre_abort", F_SUB, 8'h03, 8'h05, '0, 8'hFE, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        drive(F_MUL, 8'h10, 8'h10, '0, 8'h00, 8'h77, 3'd7, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk_reset("abort");
        @(posedge clk);
        rst = 1'b0;
        ov_seen = 0;
        repeat (W + 3) begin
            @(negedge clk); #1;
            if (out_valid === 1'b1) ov_seen++;
        end
        chk("abort:no_result", ov_seen, 0);
        chk("abort:busy", 32'(busy), 32'd0);

        // randomized ops against the reference model
        for (int i = 0; i < 300; i++) begin
            fs = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            sh = SHW'($urandom_range(0, (1 << SHW) - 1));
            model(fs, a, b, sh, ef, ec, ev, eill);
            run_op($sformatf("rnd%0d_fs%0h", i, fs), fs, a, b, sh, ef, ec, ev, eill);
        end

        @(posedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
